// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_* stage family: the canonical RISC-V NOP
// and the occupancy encoding used by every skid-buffered stage register.
package pipe_pkg;
  localparam logic [31:0] RV_NOP = 32'h0000_0013;
  typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_FULL} occ_e;
endpackage

// File: rtl/pipe_sat_ctr.sv
// Saturating event counter: sticks at all-ones, cleared only by reset.
module pipe_sat_ctr #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk) begin
    if (reset)                    count <= '0;
    else if (inc && count != '1)  count <= count + CNT_W'(1);
  end
endmodule

// File: rtl/pipe_if_id_skid.sv
// IF->ID stage register with valid/ready handshake, 2-entry skid storage and flush.
// Optional perf counters are built when PIPE_IF_ID_PERF_EN is defined.
module pipe_if_id_skid
  import pipe_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter logic [ILEN-1:0] NOP_INST = ILEN'(RV_NOP)
`ifdef PIPE_IF_ID_PERF_EN
  , parameter int            CNT_W    = 32
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [ILEN-1:0] in_inst,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_inst
`ifdef PIPE_IF_ID_PERF_EN
  , output logic [CNT_W-1:0] perf_stall_cnt
  , output logic [CNT_W-1:0] perf_flush_cnt
`endif
);
  occ_e            state;
  logic [XLEN-1:0] skid_pc;
  logic [ILEN-1:0] skid_inst;
  logic            push, pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // out_pc/out_inst are the main slot itself; it is scrubbed to 0/NOP whenever
  // it empties so decode never sees stale data with out_valid low.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state     <= OCC_EMPTY;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_inst  <= NOP_INST;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        OCC_EMPTY: if (push) begin
          state     <= OCC_ONE;
          out_valid <= 1'b1;
          out_pc    <= in_pc;
          out_inst  <= in_inst;
        end
        OCC_ONE: begin
          if (push && pop) begin
            out_pc   <= in_pc;
            out_inst <= in_inst;
          end else if (push) begin
            state     <= OCC_FULL;
            skid_pc   <= in_pc;
            skid_inst <= in_inst;
            in_ready  <= 1'b0;
          end else if (pop) begin
            state     <= OCC_EMPTY;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= NOP_INST;
          end
        end
        OCC_FULL: if (pop) begin
          state    <= OCC_ONE;
          out_pc   <= skid_pc;
          out_inst <= skid_inst;
          in_ready <= 1'b1;
        end
        default: begin
          state     <= OCC_EMPTY;
          out_valid <= 1'b0;
          out_pc    <= '0;
          out_inst  <= NOP_INST;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_IF_ID_PERF_EN
  logic flush_drop;
  // A main entry popped in the flush cycle was consumed, not dropped.
  assign flush_drop = flush & ((state == OCC_FULL) | (state == OCC_ONE & !out_ready) | push);

  pipe_sat_ctr #(.CNT_W(CNT_W)) u_stall_ctr (
    .clk(clk), .reset(reset), .inc(out_valid & !out_ready), .count(perf_stall_cnt)
  );
  pipe_sat_ctr #(.CNT_W(CNT_W)) u_flush_ctr (
    .clk(clk), .reset(reset), .inc(flush_drop), .count(perf_flush_cnt)
  );
`endif
endmodule

// File: tb/tb_pipe_if_id_skid.sv
// Directed bench for pipe_if_id_skid: vector table plus reset-mid-FULL and perf sequences.
module tb_pipe_if_id_skid;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, out_pc, out_inst;
`ifdef PIPE_IF_ID_PERF_EN
  logic [3:0]  perf_stall_cnt, perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_if_id_skid #(
    .XLEN(32), .ILEN(32), .NOP_INST(32'h0000_0013)
`ifdef PIPE_IF_ID_PERF_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
`ifdef PIPE_IF_ID_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    logic        e_v;
    logic [31:0] e_pc;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hC0DE_0000 | {16'h0, pc[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl,
                     input logic e_v, input logic [31:0] e_pc, input logic e_rdy);
    vec_t v;
    v.iv = iv; v.pc = pc; v.ordy = ordy; v.fl = fl;
    v.e_v = e_v; v.e_pc = e_pc; v.e_rdy = e_rdy;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
    in_valid = iv; in_pc = pc; in_inst = inst_of(pc); out_ready = ordy; flush = fl;
    @(posedge clk); #1;
  endtask

  task automatic chk_out(input string tag, input logic e_v, input logic [31:0] e_pc, input logic e_rdy);
    chk({tag, " out_valid"}, {31'h0, out_valid}, {31'h0, e_v});
    chk({tag, " out_pc"},    out_pc,   e_v ? e_pc : 32'h0);
    chk({tag, " out_inst"},  out_inst, e_v ? inst_of(e_pc) : 32'h0000_0013);
    chk({tag, " in_ready"},  {31'h0, in_ready}, {31'h0, e_rdy});
  endtask

  initial begin
    //  iv  pc      ordy fl   e_v e_pc    e_rdy
    // streaming
    add(1, 32'h000, 1, 0,   1, 32'h000, 1);
    add(1, 32'h004, 1, 0,   1, 32'h004, 1);
    add(1, 32'h008, 1, 0,   1, 32'h008, 1);
    add(0, 32'h000, 1, 0,   0, 32'h000, 1);
    // stall into skid, held outputs, drain in order
    add(1, 32'h100, 0, 0,   1, 32'h100, 1);
    add(1, 32'h104, 0, 0,   1, 32'h100, 0);
    add(1, 32'h108, 0, 0,   1, 32'h100, 0);
    add(0, 32'h000, 1, 0,   1, 32'h104, 1);
    add(0, 32'h000, 1, 0,   0, 32'h000, 1);
    // flush in FULL with a wrong-path push
    add(1, 32'h200, 0, 0,   1, 32'h200, 1);
    add(1, 32'h204, 0, 0,   1, 32'h200, 0);
    add(1, 32'h208, 0, 1,   0, 32'h000, 1);
    add(0, 32'h000, 1, 0,   0, 32'h000, 1);
    // simultaneous push+pop in ONE
    add(1, 32'h300, 0, 0,   1, 32'h300, 1);
    add(1, 32'h304, 1, 0,   1, 32'h304, 1);
    add(0, 32'h000, 0, 0,   1, 32'h304, 1);
    add(0, 32'h000, 1, 0,   0, 32'h000, 1);
    // flush from EMPTY discards the push; flush from ONE with pop
    add(1, 32'h400, 1, 1,   0, 32'h000, 1);
    add(1, 32'h500, 0, 0,   1, 32'h500, 1);
    add(0, 32'h000, 1, 1,   0, 32'h000, 1);

    reset = 1'b1; in_valid = 0; in_pc = 0; in_inst = 0; out_ready = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 32'h0, 1'b1);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      begin
        drive(vecs[i].iv, vecs[i].pc, vecs[i].ordy, vecs[i].fl);
        chk_out($sformatf("vec%0d", i), vecs[i].e_v, vecs[i].e_pc, vecs[i].e_rdy);
      end

    // reset while FULL discards both entries
    drive(1, 32'h700, 0, 0);
    drive(1, 32'h704, 0, 0);
    chk_out("prefull", 1'b1, 32'h700, 1'b0);
    reset = 1'b1;
    drive(0, 32'h0, 0, 0);
    chk_out("rst_full", 1'b0, 32'h0, 1'b1);
    reset = 1'b0;
    drive(0, 32'h0, 1, 0);
    chk_out("post_rst", 1'b0, 32'h0, 1'b1);

`ifdef PIPE_IF_ID_PERF_EN
    reset = 1'b1;
    drive(0, 32'h0, 0, 0);
    chk("perf_stall_rst", {28'h0, perf_stall_cnt}, 32'd0);
    chk("perf_flush_rst", {28'h0, perf_flush_cnt}, 32'd0);
    reset = 1'b0;
    drive(1, 32'h600, 0, 0);
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("perf_stall_sat", {28'h0, perf_stall_cnt}, 32'd15);
    drive(0, 32'h0, 0, 1);
    chk("perf_flush", {28'h0, perf_flush_cnt}, 32'd1);
    drive(0, 32'h0, 0, 1);
    chk("perf_flush_empty", {28'h0, perf_flush_cnt}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
